// File: rtl/apu_aout_upsampler_pkg.sv
// apu_aout_upsampler_pkg: default widths and sequencer states shared by the audio-out upsampler.
package apu_aout_upsampler_pkg;
    localparam int APU_W_SAMPLE = 16;
    localparam int APU_W_FRAME  = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STARVE} state_t;
endpackage

// File: rtl/apu_sample_fifo.sv
// apu_sample_fifo: synchronous FIFO holding incoming mixer samples until a segment start pops them.
module apu_sample_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty,
    output logic [AW:0]  o_level
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    // Fullness comes from the registered count, so a same-cycle pop never frees a slot for a push.
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_level = r_cnt;
    assign o_data  = r_mem[r_rd];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= i_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/apu_aout_upsampler.sv
// apu_aout_upsampler: FIFO-fed upsampler emitting one offset-binary sample per 16-clk PWM frame.
// APU_AOUT_UPSAMPLE_INTERP_EN selects linear interpolation; undefined gives zero-order hold.
module apu_aout_upsampler
    import apu_aout_upsampler_pkg::*;
#(
    parameter int W_SAMPLE   = APU_W_SAMPLE,
    parameter int W_FRAME    = APU_W_FRAME,
    parameter int RATE_LOG2  = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [W_SAMPLE-1:0]           in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [W_SAMPLE-1:0]           out_data,
    output logic                          out_tick,
    output logic                          underrun,
    input  logic                          underrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int W_SEG = (RATE_LOG2 > 0) ? RATE_LOG2 : 1;
    localparam logic [W_SAMPLE-1:0] MIDSCALE = {1'b1, {(W_SAMPLE-1){1'b0}}};

    state_t              r_state;
    logic [W_FRAME-1:0]  r_frame_ctr;
    logic [W_SEG-1:0]    r_seg_ctr;
    logic [W_SAMPLE-1:0] r_next;
    logic [W_SAMPLE-1:0] w_head;
    logic [W_SAMPLE-1:0] w_run_out;
    logic                w_full;
    logic                w_empty;
    logic                w_boundary;
    logic                w_start;
    logic                w_starve;

    function automatic logic [W_SAMPLE-1:0] to_offset(input logic [W_SAMPLE-1:0] s);
        return {~s[W_SAMPLE-1], s[W_SAMPLE-2:0]};
    endfunction

    apu_sample_fifo #(.W(W_SAMPLE), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_data  (in_data),
        .i_pop   (w_start),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign out_tick   = &r_frame_ctr;
    assign in_ready   = !w_full;
    assign w_boundary = out_tick && ((RATE_LOG2 == 0) || (&r_seg_ctr));
    assign w_start    = out_tick && !w_empty && ((r_state != ST_RUN) || w_boundary);
    assign w_starve   = w_boundary && w_empty && (r_state == ST_RUN);

`ifdef APU_AOUT_UPSAMPLE_INTERP_EN
    localparam int W_ACC = W_SAMPLE + RATE_LOG2 + 1;

    logic signed [W_SAMPLE:0]    r_delta;
    logic signed [W_ACC-1:0]     r_acc;
    logic signed [W_ACC-1:0]     w_acc_nxt;
    logic        [W_SAMPLE-1:0]  w_s;

    // acc holds cur*2^R + delta*k; the sample sits in the middle bits since it never leaves [cur, next].
    assign w_acc_nxt = r_acc + W_ACC'(r_delta);
    assign w_s       = w_acc_nxt[RATE_LOG2 +: W_SAMPLE];
    assign w_run_out = to_offset(w_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_delta <= '0;
            r_acc   <= '0;
        end else if (w_start) begin
            r_delta <= $signed({w_head[W_SAMPLE-1], w_head}) - $signed({r_next[W_SAMPLE-1], r_next});
            r_acc   <= W_ACC'($signed(r_next)) <<< RATE_LOG2;
        end else if (w_starve) begin
            r_delta <= '0;
        end else if (out_tick && r_state == ST_RUN) begin
            r_acc <= w_acc_nxt;
        end
    end
`else
    assign w_run_out = out_data;
`endif

    // The segment-start edge emits frame 0 of the new segment, which is the previous next sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_ctr <= '0;
            r_seg_ctr   <= '0;
            r_state     <= ST_IDLE;
            r_next      <= '0;
            out_data    <= MIDSCALE;
            underrun    <= 1'b0;
        end else begin
            r_frame_ctr <= r_frame_ctr + 1'b1;
            underrun    <= w_starve || (underrun && !underrun_clr);
            if (out_tick) r_seg_ctr <= w_start ? '0 : r_seg_ctr + 1'b1;
            if (w_start) begin
                r_state  <= ST_RUN;
                r_next   <= w_head;
                out_data <= to_offset(r_next);
            end else if (w_starve) begin
                r_state  <= ST_STARVE;
                out_data <= to_offset(r_next);
            end else if (out_tick && r_state == ST_RUN) begin
                out_data <= w_run_out;
            end
        end
    end
endmodule

// File: tb/tb_apu_aout_upsampler.sv
// tb_apu_aout_upsampler: directed and randomized checks of the upsampler at 4 frames per segment.
module tb_apu_aout_upsampler;
    localparam int FD = 4;
    localparam int N  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        underrun_clr = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        out_tick;
    logic        underrun;
    logic [15:0] out_data;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    int          q[$];
    int          m_fc, m_k, m_cur, m_next, m_mode;
    logic [15:0] m_out;
    logic        m_und;
    logic        m_edge_tick;

`ifdef APU_AOUT_UPSAMPLE_INTERP_EN
    localparam bit INTERP = 1'b1;
    logic [15:0] exp_ramp [6]  = '{16'h8000, 16'h8400, 16'h8800, 16'h8C00, 16'h9000, 16'h9000};
    logic [15:0] exp_b2b  [10] = '{16'h8000, 16'h8400, 16'h8800, 16'h8C00, 16'h9000,
                                   16'h8800, 16'h8000, 16'h7800, 16'h7000, 16'h7000};
    logic [15:0] exp_ext  [10] = '{16'h8000, 16'h9FFF, 16'hBFFF, 16'hDFFF, 16'hFFFF,
                                   16'hBFFF, 16'h7FFF, 16'h3FFF, 16'h0000, 16'h0000};
`else
    localparam bit INTERP = 1'b0;
    logic [15:0] exp_ramp [6]  = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h9000, 16'h9000};
    logic [15:0] exp_b2b  [10] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h9000,
                                   16'h9000, 16'h9000, 16'h9000, 16'h7000, 16'h7000};
    logic [15:0] exp_ext  [10] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF,
                                   16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
`endif

    always #5 clk = ~clk;

    apu_aout_upsampler #(.W_SAMPLE(16), .W_FRAME(4), .RATE_LOG2(2), .FIFO_DEPTH(FD)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_tick     (out_tick),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .fifo_level   (fifo_level)
    );

    task automatic m_reset();
        q.delete();
        m_fc = 0; m_k = 0; m_cur = 0; m_next = 0; m_mode = 0;
        m_out = 16'h8000;
        m_und = 1'b0;
    endtask

    // One clock: drive inputs, advance the frame-level reference model, sample 1 time unit later.
    task automatic cyc(input logic v, input logic [15:0] d, input logic clr);
        bit acc, set;
        int s;
        in_valid = v; in_data = d; underrun_clr = clr;
        @(posedge clk);
        acc = v && (q.size() < FD);
        set = 1'b0;
        s = 0;
        m_edge_tick = !rst && (m_fc == 15);
        if (rst) begin
            m_reset();
        end else begin
            if (m_edge_tick) begin
                if (m_mode != 1 || m_k == N - 1) begin
                    if (q.size() > 0) begin
                        m_cur = m_next; m_next = q.pop_front(); m_k = 0; m_mode = 1; s = m_cur;
                    end else if (m_mode == 1) begin
                        m_mode = 2; set = 1'b1; s = m_next;
                    end else begin
                        s = (m_mode == 0) ? 0 : m_next;
                    end
                end else begin
                    m_k++;
                    s = INTERP ? m_cur + (((m_next - m_cur) * m_k) >>> 2) : m_cur;
                end
                m_out = 16'(s) ^ 16'h8000;
            end
            m_und = set || (m_und && !clr);
            if (acc) q.push_back(int'($signed(d)));
            m_fc = (m_fc + 1) % 16;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_data !== 16'h8000) begin errors++; $display("FAIL reset_out got %h want 8000", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (out_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", out_tick); end
        for (int i = 0; i < 4 * 16; i++) begin
            cyc(0, 0, 0);
            checks++;
            if (out_data !== 16'h8000 || underrun !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL idle_hold cyc %0d got out=%h und=%b rdy=%b want 8000/0/1", i, out_data, underrun, in_ready);
            end
            checks++;
            if (out_tick !== (m_fc == 15)) begin errors++; $display("FAIL idle_tick cyc %0d got %b want %b", i, out_tick, m_fc == 15); end
        end
    endtask

    task automatic test_ramp();
        int n = 0;
        do_reset();
        cyc(1, 16'h1000, 0);
        for (int i = 0; i < 8 * 16 && n < 6; i++) begin
            cyc(0, 0, 0);
            if (m_edge_tick) begin
                checks++; if (out_data !== exp_ramp[n]) begin errors++; $display("FAIL ramp_out[%0d] got %h want %h", n, out_data, exp_ramp[n]); end
                checks++; if (underrun !== (n >= 4)) begin errors++; $display("FAIL ramp_underrun[%0d] got %b want %b", n, underrun, n >= 4); end
                n++;
            end
        end
        checks++; if (n != 6) begin errors++; $display("FAIL ramp_timeout got %0d frames want 6", n); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        do_reset();
        cyc(1, 16'h1000, 0);
        cyc(1, 16'hF000, 0);
        for (int i = 0; i < 12 * 16 && n < 10; i++) begin
            cyc(0, 0, 0);
            if (m_edge_tick) begin
                checks++; if (out_data !== exp_b2b[n]) begin errors++; $display("FAIL b2b_out[%0d] got %h want %h", n, out_data, exp_b2b[n]); end
                n++;
            end
        end
        checks++; if (n != 10) begin errors++; $display("FAIL b2b_timeout got %0d frames want 10", n); end
    endtask

    task automatic test_extremes();
        int n = 0;
        logic [15:0] prev = '0;
        do_reset();
        cyc(1, 16'h7FFF, 0);
        cyc(1, 16'h8000, 0);
        for (int i = 0; i < 12 * 16 && n < 10; i++) begin
            cyc(0, 0, (m_fc == 15) && n == 8);
            if (m_edge_tick) begin
                checks++; if (out_data !== exp_ext[n]) begin errors++; $display("FAIL ext_out[%0d] got %h want %h", n, out_data, exp_ext[n]); end
                if (n >= 5) begin
                    checks++; if (out_data > prev) begin errors++; $display("FAIL ext_monotonic[%0d] got %h after %h", n, out_data, prev); end
                end
                checks++; if (underrun !== (n >= 8)) begin errors++; $display("FAIL ext_underrun[%0d] got %b want %b", n, underrun, n >= 8); end
                prev = out_data;
                n++;
            end
        end
        checks++; if (n != 10) begin errors++; $display("FAIL ext_timeout got %0d frames want 10", n); end
        cyc(0, 0, 1);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ext_clear got %b want 0", underrun); end
    endtask

    task automatic test_fifo_full();
        int lvl;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc((i < 5) || (i == 15), 16'($urandom), 0);
            lvl = (i == 15) ? 3 : ((i < 4) ? i + 1 : 4);
            checks++; if (fifo_level !== 3'(lvl)) begin errors++; $display("FAIL full_level cyc %0d got %0d want %0d", i, fifo_level, lvl); end
            checks++; if (in_ready !== (lvl < 4)) begin errors++; $display("FAIL full_ready cyc %0d got %b want %b", i, in_ready, lvl < 4); end
        end
        cyc(1, 16'h1234, 0);
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_refill got %0d want 4", fifo_level); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        cyc(1, 16'h4000, 0);
        cyc(1, 16'hC000, 0);
        cyc(1, 16'h2000, 0);
        cyc(1, 16'hE000, 0);
        repeat (6 * 16 + 5) cyc(0, 0, 0);
        checks++; if (fifo_level !== 3'(q.size())) begin errors++; $display("FAIL midrst_pre_level got %0d want %0d", fifo_level, q.size()); end
        rst = 1'b1;
        cyc(0, 0, 0);
        rst = 1'b0;
        checks++; if (out_data !== 16'h8000) begin errors++; $display("FAIL midrst_out got %h want 8000", out_data); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL midrst_level got %0d want 0", fifo_level); end
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0);
            if (m_edge_tick) begin
                checks++; if (out_data !== 16'h8000 || fifo_level !== 3'd0) begin errors++; $display("FAIL midrst_frame got out=%h lvl=%0d want 8000/0", out_data, fifo_level); end
            end
        end
    endtask

    task automatic test_random();
        logic        v;
        logic [15:0] d;
        int          sel;
        do_reset();
        for (int i = 0; i < 60 * 16; i++) begin
            v = (i < 480) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 199) == 0);
            sel = $urandom_range(0, 9);
            d = (sel == 0) ? 16'h7FFF : (sel == 1) ? 16'h8000 : 16'($urandom);
            cyc(v, d, $urandom_range(0, 49) == 0);
            checks++; if (out_data !== m_out) begin errors++; $display("FAIL rand_out cyc %0d got %h want %h", i, out_data, m_out); end
            checks++; if (underrun !== m_und) begin errors++; $display("FAIL rand_underrun cyc %0d got %b want %b", i, underrun, m_und); end
            checks++; if (fifo_level !== 3'(q.size())) begin errors++; $display("FAIL rand_level cyc %0d got %0d want %0d", i, fifo_level, q.size()); end
            checks++; if (in_ready !== (q.size() < FD)) begin errors++; $display("FAIL rand_ready cyc %0d got %b want %b", i, in_ready, q.size() < FD); end
            checks++; if (out_tick !== (m_fc == 15)) begin errors++; $display("FAIL rand_tick cyc %0d got %b want %b", i, out_tick, m_fc == 15); end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_ramp();
        test_back_to_back();
        test_extremes();
        test_fifo_full();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
